fifo_param: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's single-clock fifo.
- Configurable data width, depth, almost-full/almost-empty thresholds, and read mode (registered output or first-word-fall-through).
- Adds occupancy count, synchronous flush, and defined simultaneous read/write behaviour at full and empty.
- Sits between producer and consumer blocks in the same clock domain.

---
 rtl/fifo_param_if.sv | 28 ++
 rtl/fifo_param.sv | 103 ++++++++++
 tb/tb_fifo_param.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// Producer/consumer bundle for fifo_param: strobes, data, status flags and occupancy.
interface fifo_param_if #(
   parameter int unsigned RW = 8,
   parameter int unsigned AB = 5
);
   logic          clr;
   logic          ws;
   logic          rs;
   logic [RW-1:0] in;
   logic [RW-1:0] o;
   logic          fs;
   logic          es;
   logic          afs;
   logic          aes;
   logic          of;
   logic          uf;
   logic [AB:0]   cnt;

   modport master (
      output clr, ws, rs, in,
      input  o, fs, es, afs, aes, of, uf, cnt
   );

   modport slave (
      input  clr, ws, rs, in,
      output o, fs, es, afs, aes, of, uf, cnt
   );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, flush, almost-full/empty
// thresholds and selectable registered or first-word-fall-through read port.
module fifo_param #(
   parameter int unsigned RW    = 8,
   parameter int unsigned AB    = 5,
   parameter int unsigned AF_TH = 28,
   parameter int unsigned AE_TH = 4,
   parameter int unsigned FWFT  = 0
) (
   input logic         c,
   input logic         re,
   fifo_param_if.slave bus
);
   localparam int unsigned DEPTH   = 2 ** AB;
   localparam logic [AB:0] DEPTH_W = (AB + 1)'(DEPTH);
   localparam logic [AB:0] AF_W    = (AB + 1)'(AF_TH);
   localparam logic [AB:0] AE_W    = (AB + 1)'(AE_TH);
   localparam logic [AB:0] ONE     = {{AB{1'b0}}, 1'b1};

   logic [RW-1:0] mem_q [DEPTH];
   logic [AB:0]   wp_q, wp_d;
   logic [AB:0]   rp_q, rp_d;
   logic [AB:0]   cnt_q, cnt_d;
   logic [RW-1:0] o_q, o_d;
   logic          of_q, of_d;
   logic          uf_q, uf_d;
   logic          fs, es, wa, ra, wr_en;
   logic [RW-1:0] head;

   // Status flags decoded from the registered occupancy count.
   always_comb begin
      es   = (cnt_q == '0);
      fs   = (cnt_q == DEPTH_W);
      head = mem_q[rp_q[AB-1:0]];
   end

   // Accept decisions and next-state for pointers, count, output and pulses.
   // A write at full is still taken when a read frees a slot on the same edge.
   always_comb begin
      wa    = bus.ws & (~fs | (bus.rs & ~es));
      ra    = bus.rs & ~es;
      wr_en = 1'b0;
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      o_d   = o_q;
      of_d  = 1'b0;
      uf_d  = 1'b0;
      if (bus.clr) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         wr_en = wa;
         if (wa) wp_d = wp_q + ONE;
         if (ra) rp_d = rp_q + ONE;
         case ({wa, ra})
            2'b10:   cnt_d = cnt_q + ONE;
            2'b01:   cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
         endcase
         of_d = bus.ws & ~wa;
         uf_d = bus.rs & es;
         if ((FWFT == 0) && ra) o_d = head;
      end
   end

   // Storage array; contents are not reset.
   always_ff @(posedge c) begin
      if (wr_en) mem_q[wp_q[AB-1:0]] <= bus.in;
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge c or posedge re) begin
      if (re) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         o_q   <= '0;
         of_q  <= 1'b0;
         uf_q  <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         o_q   <= o_d;
         of_q  <= of_d;
         uf_q  <= uf_d;
      end
   end

   // Output drive; in fall-through mode the head word is shown straight from memory.
   always_comb begin
      bus.o   = (FWFT != 0) ? (es ? '0 : head) : o_q;
      bus.fs  = fs;
      bus.es  = es;
      bus.afs = (cnt_q >= AF_W);
      bus.aes = (cnt_q <= AE_W);
      bus.of  = of_q;
      bus.uf  = uf_q;
      bus.cnt = cnt_q;
   end
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: registered-output and fall-through instances, scoreboard
// queues filled by the stimulus and drained by per-instance output monitors.
module tb_fifo_param;
   logic c = 1'b0;
   logic re = 1'b1;
   int unsigned total = 0;
   int unsigned bad = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic pend_a = 1'b0;

   always #5 c = ~c;

   fifo_param_if #(.RW(8), .AB(5)) a_if ();
   fifo_param_if #(.RW(8), .AB(5)) b_if ();

   fifo_param #(.RW(8), .AB(5), .AF_TH(28), .AE_TH(4), .FWFT(0)) u_a (
      .c(c), .re(re), .bus(a_if.slave));
   fifo_param #(.RW(8), .AB(5), .AF_TH(28), .AE_TH(4), .FWFT(1)) u_b (
      .c(c), .re(re), .bus(b_if.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drv_a(input logic w, input logic r, input logic [7:0] d, input logic cl);
      a_if.ws = w; a_if.rs = r; a_if.in = d; a_if.clr = cl;
      @(posedge c); #1;
   endtask

   task automatic drv_b(input logic w, input logic r, input logic [7:0] d, input logic cl);
      b_if.ws = w; b_if.rs = r; b_if.in = d; b_if.clr = cl;
      @(posedge c); #1;
   endtask

   // Registered-output monitor: a read accepted at an edge is checked one negedge later.
   always @(negedge c) begin
      logic [7:0] e;
      if (pend_a) begin
         total++;
         if (qa.size() == 0) begin
            bad++;
            $display("FAIL a_unexpected_read: got %0h expected none", a_if.o);
         end else begin
            e = qa.pop_front();
            total--;
            chk("a_rd_data", {24'd0, a_if.o}, {24'd0, e});
         end
      end
      pend_a = a_if.rs & ~a_if.es & ~a_if.clr & ~re;
   end

   // Fall-through monitor: the word on o is the one consumed by the coming edge.
   always @(negedge c) begin
      logic [7:0] e;
      if (b_if.rs & ~b_if.es & ~b_if.clr & ~re) begin
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_read: got %0h expected none", b_if.o);
         end else begin
            e = qb.pop_front();
            chk("b_rd_data", {24'd0, b_if.o}, {24'd0, e});
         end
      end
   end

   initial begin
      a_if.ws = 0; a_if.rs = 0; a_if.in = '0; a_if.clr = 0;
      b_if.ws = 0; b_if.rs = 0; b_if.in = '0; b_if.clr = 0;
      repeat (3) @(posedge c);
      #1;
      chk("rst_cnt", a_if.cnt, 0);
      chk("rst_es", a_if.es, 1);
      chk("rst_aes", a_if.aes, 1);
      chk("rst_fs", a_if.fs, 0);
      chk("rst_afs", a_if.afs, 0);
      chk("rst_o", a_if.o, 0);
      chk("rst_of", a_if.of, 0);
      chk("rst_uf", a_if.uf, 0);
      re = 0;
      drv_a(0, 0, 0, 0);

      // fill 0..31
      for (int i = 0; i < 32; i++) begin
         drv_a(1, 0, 8'(i), 0);
         chk("fill_cnt", a_if.cnt, i + 1);
         chk("fill_es", a_if.es, 0);
         chk("fill_aes", a_if.aes, (i + 1 <= 4) ? 1 : 0);
         chk("fill_afs", a_if.afs, (i + 1 >= 28) ? 1 : 0);
         chk("fill_fs", a_if.fs, (i == 31) ? 1 : 0);
      end

      // overflow
      drv_a(1, 0, 8'hAA, 0);
      chk("ovf_of", a_if.of, 1);
      chk("ovf_cnt", a_if.cnt, 32);
      drv_a(0, 0, 0, 0);
      chk("ovf_of_clear", a_if.of, 0);

      // drain 0..31
      for (int i = 0; i < 32; i++) begin
         qa.push_back(8'(i));
         drv_a(0, 1, 0, 0);
      end
      chk("drain_es", a_if.es, 1);
      drv_a(0, 0, 0, 0);
      chk("drain_o_hold", a_if.o, 31);

      // underflow
      drv_a(0, 1, 0, 0);
      chk("unf_uf", a_if.uf, 1);
      chk("unf_o", a_if.o, 31);
      drv_a(0, 0, 0, 0);
      chk("unf_uf_clear", a_if.uf, 0);
      chk("unf_cnt", a_if.cnt, 0);

      // simultaneous read/write at full
      for (int i = 0; i < 32; i++) drv_a(1, 0, 8'(i), 0);
      chk("sim_full_fs", a_if.fs, 1);
      qa.push_back(8'd0);
      drv_a(1, 1, 8'h55, 0);
      chk("sim_full_cnt", a_if.cnt, 32);
      chk("sim_full_of", a_if.of, 0);
      for (int i = 1; i < 32; i++) begin
         qa.push_back(8'(i));
         drv_a(0, 1, 0, 0);
      end
      qa.push_back(8'h55);
      drv_a(0, 1, 0, 0);
      chk("sim_full_drain_es", a_if.es, 1);

      // simultaneous read/write at empty
      drv_a(1, 1, 8'h77, 0);
      chk("sim_empty_uf", a_if.uf, 1);
      chk("sim_empty_cnt", a_if.cnt, 1);
      qa.push_back(8'h77);
      drv_a(0, 1, 0, 0);
      chk("sim_empty_es", a_if.es, 1);

      // wrap-around
      for (int i = 0; i < 20; i++) drv_a(1, 0, 8'(i + 50), 0);
      for (int i = 0; i < 20; i++) begin
         qa.push_back(8'(i + 50));
         drv_a(0, 1, 0, 0);
      end
      for (int i = 0; i < 32; i++) drv_a(1, 0, 8'(i + 100), 0);
      chk("wrap_fs", a_if.fs, 1);
      chk("wrap_cnt", a_if.cnt, 32);
      for (int i = 0; i < 32; i++) begin
         qa.push_back(8'(i + 100));
         drv_a(0, 1, 0, 0);
      end
      drv_a(0, 0, 0, 0);
      chk("wrap_o_last", a_if.o, 131);

      // flush with a concurrent write
      for (int i = 1; i <= 10; i++) drv_a(1, 0, 8'(i), 0);
      drv_a(1, 0, 8'hEE, 1);
      chk("clr_cnt", a_if.cnt, 0);
      chk("clr_es", a_if.es, 1);
      chk("clr_of", a_if.of, 0);
      chk("clr_o_hold", a_if.o, 131);
      drv_a(1, 0, 8'h11, 0);
      chk("post_clr_cnt", a_if.cnt, 1);
      qa.push_back(8'h11);
      drv_a(0, 1, 0, 0);
      drv_a(0, 0, 0, 0);
      chk("post_clr_es", a_if.es, 1);

      // asynchronous reset mid-burst
      for (int i = 0; i < 5; i++) drv_a(1, 0, 8'(i), 0);
      chk("burst_cnt", a_if.cnt, 5);
      #2 re = 1;
      #1;
      chk("async_cnt", a_if.cnt, 0);
      chk("async_es", a_if.es, 1);
      chk("async_aes", a_if.aes, 1);
      chk("async_o", a_if.o, 0);
      a_if.ws = 0;
      @(posedge c); #1;
      re = 0;
      drv_a(0, 0, 0, 0);
      chk("post_rst_cnt", a_if.cnt, 0);

      // fall-through instance
      chk("fwft_empty_o", b_if.o, 0);
      chk("fwft_empty_es", b_if.es, 1);
      drv_b(1, 0, 8'h3C, 0);
      chk("fwft_first_o", b_if.o, 8'h3C);
      chk("fwft_first_es", b_if.es, 0);
      drv_b(1, 0, 8'h3D, 0);
      chk("fwft_second_o", b_if.o, 8'h3C);
      qb.push_back(8'h3C);
      drv_b(0, 1, 0, 0);
      chk("fwft_after_read_o", b_if.o, 8'h3D);
      qb.push_back(8'h3D);
      drv_b(0, 1, 0, 0);
      chk("fwft_drained_es", b_if.es, 1);
      chk("fwft_drained_o", b_if.o, 0);
      drv_b(0, 0, 0, 0);

      repeat (2) @(posedge c);
      #1;
      chk("qa_left", qa.size(), 0);
      chk("qb_left", qb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
